// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state encoding,
// opcode/funct constants, aluop encodings and the ALU operation codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from the controller's aluop and the instruction funct
// field to the 3-bit ALU operation code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // aluop selects a fixed add/sub, or defers to funct for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM plus the Mealy PC enable.
// Optional bne support is enabled by defining MC_CONTROLLER_BNE_EN.
module mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t     state_r;
    state_t     next_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       bne_br_s;
    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [1:0] aluop_s;
    logic [1:0] aluop_gated_s;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode and per-state Moore outputs
    always_comb begin
        next_s     = ST_FETCH;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        bne_br_s   = 1'b0;
        iord_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        aluop_s    = ALUOP_ADD;
        case (state_r)
            ST_FETCH: begin
                alusrcb_s = 2'b01;
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                next_s    = ST_DECODE;
            end
            ST_DECODE: begin
                alusrcb_s = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_s = ST_MEMADR;
                    OP_RTYPE:     next_s = ST_EXECUTE;
                    OP_BEQ:       next_s = ST_BRANCH;
                    OP_ADDI:      next_s = ST_ADDIEXEC;
                    OP_J:         next_s = ST_JUMP;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       next_s = ST_BRANCH;
`endif
                    default:      next_s = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                next_s    = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                iord_s = 1'b1;
                next_s = ST_MEMWB;
            end
            ST_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                next_s     = ST_FETCH;
            end
            ST_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                next_s     = ST_FETCH;
            end
            ST_EXECUTE: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_FUNCT;
                next_s    = ST_ALUWB;
            end
            ST_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                next_s     = ST_FETCH;
            end
            ST_ADDIEXEC: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                next_s    = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                regwrite_s = 1'b1;
                next_s     = ST_FETCH;
            end
            ST_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_SUB;
                pcsrc_s   = 2'b01;
                branch_s  = (op == OP_BEQ);
`ifdef MC_CONTROLLER_BNE_EN
                bne_br_s  = (op == OP_BNE);
`else
                bne_br_s  = 1'b0;
`endif
                next_s    = ST_FETCH;
            end
            ST_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
                next_s    = ST_FETCH;
            end
            default: next_s = ST_FETCH;
        endcase
    end

    // While reset is low every output is forced to its idle value, so an
    // aborted instruction can never leave a write enable high.
    assign aluop_gated_s = reset_n ? aluop_s : ALUOP_ADD;

    alu_decoder u_alu_decoder (
        .aluop      (aluop_gated_s),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    assign pcen     = reset_n & (pcwrite_s | (branch_s & zero) | (bne_br_s & ~zero));
    assign iord     = reset_n & iord_s;
    assign memwrite = reset_n & memwrite_s;
    assign irwrite  = reset_n & irwrite_s;
    assign regdst   = reset_n & regdst_s;
    assign memtoreg = reset_n & memtoreg_s;
    assign regwrite = reset_n & regwrite_s;
    assign alusrca  = reset_n & alusrca_s;
    assign alusrcb  = reset_n ? alusrcb_s : 2'b00;
    assign pcsrc    = reset_n ? pcsrc_s : 2'b00;
    assign state    = reset_n ? state_r : ST_FETCH;

endmodule
